// File: rtl/morse_pkg.sv
// Morse sequencer shared definitions: FSM state encoding, symbol encoding,
// default parameter values and a small constant helper.
// Latency: n/a (package). Backpressure: n/a (package).
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  typedef enum logic {
    SYM_DOT  = 1'b0,
    SYM_DASH = 1'b1
  } sym_t;

  localparam int DEF_MAX_SYMS    = 5;
  localparam int DEF_LETTER_GAP  = 3;
  localparam int DEF_WORD_GAP    = 7;
  localparam int DEF_SYM_TIMEOUT = 8;

  // Largest of three values; sizes the shared gap/timeout counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Morse sequencer bus: character handshake from upstream, symbol request /
// completion towards the LED FSM, and status (char_done, err).
// Ports: char_valid/char_ready/char_code/char_len, sym_strt/symbol/sym_done,
//        char_done, err. master = upstream + LED FSM side, slave = sequencer.
interface morse_sequencer_if
  import morse_pkg::*;
#(
  parameter int MAX_SYMS = DEF_MAX_SYMS
);
  logic                char_valid;
  logic                char_ready;
  logic [MAX_SYMS-1:0] char_code;
  logic [2:0]          char_len;
  logic                sym_strt;
  logic                symbol;
  logic                sym_done;
  logic                char_done;
  logic                err;

  modport master (
    output char_valid, char_code, char_len, sym_done,
    input  char_ready, sym_strt, symbol, char_done, err
  );

  modport slave (
    input  char_valid, char_code, char_len, sym_done,
    output char_ready, sym_strt, symbol, char_done, err
  );
endinterface

// File: rtl/morse_gap_cnt.sv
// Loadable down-counter shared by the inter-character gap and the symbol timeout.
// Latency: load/decrement visible the cycle after the edge; saturates at zero.
// Ports: clock, reset (sync, active-high), load_i/load_val_i, dec_i, cnt_o.
module morse_gap_cnt #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/morse_sequencer.sv
// Morse sequencer: accepts one character, issues its dots/dashes to the LED FSM
// one at a time, then holds a trailing gap and pulses char_done.
// Latency: first sym_strt the cycle after acceptance. Backpressure: char_ready
// only in IDLE; a missing sym_done for SYM_TIMEOUT cycles latches err until reset.
// Ports: clock, reset (sync, active-high), bus (morse_sequencer_if.slave).
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_SYMS    = DEF_MAX_SYMS,    // 1..7, bounded by the 3-bit char_len
  parameter int LETTER_GAP  = DEF_LETTER_GAP,  // >= 2
  parameter int WORD_GAP    = DEF_WORD_GAP,    // >= 1
  parameter int SYM_TIMEOUT = DEF_SYM_TIMEOUT  // >= 4
) (
  input  logic                   clock,
  input  logic                   reset,
  morse_sequencer_if.slave       bus
);
  localparam int         CNT_W   = $clog2(max3(WORD_GAP, LETTER_GAP, SYM_TIMEOUT) + 1);
  localparam logic [2:0] LEN_MAX = 3'(MAX_SYMS);

  state_t              state_q, state_d;
  logic [MAX_SYMS-1:0] code_q, code_d;
  logic [2:0]          len_q, len_d;
  logic [2:0]          idx_q, idx_d;

  logic [2:0]          len_sat;
  logic                accept;
  logic                last_sym;
  logic                cnt_load;
  logic                cnt_dec;
  logic [CNT_W-1:0]    cnt_val;
  logic [CNT_W-1:0]    cnt;

  assign len_sat  = (bus.char_len > LEN_MAX) ? LEN_MAX : bus.char_len;
  assign accept   = (state_q == ST_IDLE) && bus.char_valid;
  assign last_sym = (idx_q == (len_q - 3'd1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (len_sat == 3'd0) ? ST_GAP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // sym_done wins over an expiring budget in the same cycle
        if (bus.sym_done)    state_d = last_sym ? ST_GAP : ST_ISSUE;
        else if (cnt == '0)  state_d = ST_ERR;
      end
      // count never sits at 0 in GAP; <= 1 just guarantees an exit
      ST_GAP:   if (cnt <= CNT_W'(1)) state_d = ST_IDLE;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.char_ready = (state_q == ST_IDLE);
    bus.sym_strt   = (state_q == ST_ISSUE);
    bus.symbol     = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? code_q[idx_q] : SYM_DOT;
    bus.char_done  = (state_q == ST_GAP) && (cnt == CNT_W'(1));
    bus.err        = (state_q == ST_ERR);
  end

  // Character datapath: captured on acceptance, index advances per completed symbol
  always_comb begin
    code_d = code_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (accept) begin
      code_d = bus.char_code;
      len_d  = len_sat;
      idx_d  = 3'd0;
    end else if ((state_q == ST_WAIT) && bus.sym_done && !last_sym) begin
      idx_d  = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      code_q <= code_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  // Counter control. The timeout budget is loaded as SYM_TIMEOUT-1 on the way
  // into WAIT so that reaching zero with no sym_done marks the last allowed
  // WAIT cycle. The letter gap loads LETTER_GAP-1 because the sym_done cycle
  // itself is the first off-unit.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (len_sat == 3'd0)) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(WORD_GAP);
        end
      end
      ST_ISSUE: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SYM_TIMEOUT - 1);
      end
      ST_WAIT: begin
        if (bus.sym_done && last_sym) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(LETTER_GAP - 1);
        end else if (!bus.sym_done) begin
          cnt_dec  = 1'b1;
        end
      end
      ST_GAP:  cnt_dec = 1'b1;
      default: ;
    endcase
  end

  morse_gap_cnt #(.W(CNT_W)) u_gap_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt)
  );
endmodule
